// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path: FSM state encoding,
// parity selection constants and frame-length arithmetic.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } tx_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // Number of baud ticks one complete frame occupies on the line.
   function automatic int frame_ticks(input int data_bits,
                                      input int parity,
                                      input int stop_bits);
      return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
   endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake between user logic (master) and the UART transmit
// sequencer (slave).
interface uart_tx_ctrl_if #(
   parameter int DATA_BITS = 8
);

   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts a byte, enables the external baud tick
// generator and shifts start, data, optional parity and stop bits onto txd.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic           clk,
   input  logic           rst,
   uart_tx_ctrl_if.slave  bus,
   output logic           baud_en,
   input  logic           baud_tick,
   output logic           txd,
   output logic           busy,
   output logic           frame_done
);

   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
      $error("uart_tx_ctrl: DATA_BITS must be in 5..8");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_ctrl: PARITY must be 0 (none), 1 (odd) or 2 (even)");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
   end

   localparam logic [2:0] IDX_LAST  = 3'(DATA_BITS - 1);
   localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

   tx_state_t            state, state_nxt;
   logic [DATA_BITS-1:0] shreg, shreg_nxt;
   logic [2:0]           idx, idx_nxt;
   logic                 stop_cnt, stop_cnt_nxt;
   logic                 par_bit, par_bit_nxt;
   logic                 txd_nxt;
   logic                 frame_done_nxt;
   logic                 accept;
   logic                 tick;

   function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
      if (PARITY == PAR_ODD) begin
         return ~^d;
      end
      return ^d;
   endfunction

   assign bus.tx_ready = (state == S_IDLE);
   assign accept       = bus.tx_valid && (state == S_IDLE);
   // Ticks only count while the generator is enabled, so a stray tick in IDLE is inert.
   assign tick         = baud_tick && baud_en;

   always_comb begin
      state_nxt      = state;
      shreg_nxt      = shreg;
      idx_nxt        = idx;
      stop_cnt_nxt   = stop_cnt;
      par_bit_nxt    = par_bit;
      txd_nxt        = txd;
      frame_done_nxt = 1'b0;

      unique case (state)
         S_IDLE: begin
            txd_nxt = 1'b1;
            if (accept) begin
               shreg_nxt    = bus.tx_data;
               par_bit_nxt  = calc_parity(bus.tx_data);
               idx_nxt      = 3'd0;
               stop_cnt_nxt = 1'b0;
               txd_nxt      = 1'b0;
               state_nxt    = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               idx_nxt   = 3'd0;
               txd_nxt   = shreg[0];
               state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (tick) begin
               if (idx == IDX_LAST) begin
                  stop_cnt_nxt = 1'b0;
                  if (PARITY != PAR_NONE) begin
                     txd_nxt   = par_bit;
                     state_nxt = S_PARITY;
                  end else begin
                     txd_nxt   = 1'b1;
                     state_nxt = S_STOP;
                  end
               end else begin
                  // shreg[0] is the bit on the line; shifting exposes the next one.
                  idx_nxt   = idx + 3'd1;
                  txd_nxt   = shreg[1];
                  shreg_nxt = shreg >> 1;
               end
            end
         end
         S_PARITY: begin
            if (tick) begin
               stop_cnt_nxt = 1'b0;
               txd_nxt      = 1'b1;
               state_nxt    = S_STOP;
            end
         end
         S_STOP: begin
            if (tick) begin
               if (stop_cnt == STOP_LAST) begin
                  txd_nxt        = 1'b1;
                  frame_done_nxt = 1'b1;
                  state_nxt      = S_IDLE;
               end else begin
                  stop_cnt_nxt = stop_cnt + 1'b1;
               end
            end
         end
         default: begin
            txd_nxt   = 1'b1;
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         idx        <= 3'd0;
         stop_cnt   <= 1'b0;
         txd        <= 1'b1;
         baud_en    <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         stop_cnt   <= stop_cnt_nxt;
         txd        <= txd_nxt;
         baud_en    <= (state_nxt != S_IDLE);
         busy       <= (state_nxt != S_IDLE);
         frame_done <= frame_done_nxt;
      end
   end

   // Payload and parity are only meaningful after an accept, so they carry no reset.
   always_ff @(posedge clk) begin
      shreg   <= shreg_nxt;
      par_bit <= par_bit_nxt;
   end

endmodule
